// File: rtl/player_feedback.sv
// player_feedback: buzz-in lockout, answer judging and LED/buzzer feedback
// for the player controller pads. Captures the first player to buzz, judges
// the answer once the button is released, then shows the result for a fixed
// window before waiting for all buttons to be released again.
module player_feedback #(
    parameter int SHOW_CYCLES = 50000000,
    parameter int BLINK_HALF  = 6250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_active,
    input  logic       playerInputFlag,
    input  logic [1:0] firstPlayerFlag,
    input  logic [7:0] switchInput,
    input  logic [7:0] target,
    output logic [3:0] led_out,
    output logic       ready_led,
    output logic       buzzer_out,
    output logic       result_valid,
    output logic       result_correct,
    output logic [1:0] result_player
);

    // Counter widths hold the full terminal value so neither counter can
    // wrap inside one display window.
    localparam int SHOW_W  = $clog2(SHOW_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOCKED,
        JUDGE,
        SHOW,
        COOLDOWN
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          player_q, player_d;
    logic                correct_q, correct_d;
    logic [SHOW_W-1:0]   showCnt_q, showCnt_d;
    logic [BLINK_W-1:0]  blinkCnt_q, blinkCnt_d;
    logic                blinkOn_q, blinkOn_d;

    logic [3:0]          led_q, led_d;
    logic                ready_q, ready_d;
    logic                buzzer_q, buzzer_d;
    logic                valid_q, valid_d;
    logic                resCorrect_q, resCorrect_d;
    logic [1:0]          resPlayer_q, resPlayer_d;

    logic [3:0]          playerOneHot;
    logic                answerMatch;

    assign playerOneHot = 4'b0001 << player_q;
    assign answerMatch  = (switchInput == target);

    // Next-state and next-output decode; every output is derived from the
    // current state so it appears one cycle after the state that causes it.
    always_comb begin
        state_d      = state_q;
        player_d     = player_q;
        correct_d    = correct_q;
        showCnt_d    = showCnt_q;
        blinkCnt_d   = blinkCnt_q;
        blinkOn_d    = blinkOn_q;
        led_d        = 4'b0000;
        ready_d      = 1'b0;
        buzzer_d     = 1'b0;
        valid_d      = 1'b0;
        resCorrect_d = resCorrect_q;
        resPlayer_d  = resPlayer_q;

        if (state_q != IDLE && !game_active) begin
            // Game aborted: drop all feedback and never issue a result strobe.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_d = game_active;
                    if (game_active && playerInputFlag) begin
                        player_d = firstPlayerFlag;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    led_d = playerOneHot;
                    if (!playerInputFlag) begin
                        state_d = JUDGE;
                    end
                end
                JUDGE: begin
                    led_d        = playerOneHot;
                    valid_d      = 1'b1;
                    resCorrect_d = answerMatch;
                    resPlayer_d  = player_q;
                    correct_d    = answerMatch;
                    showCnt_d    = '0;
                    blinkCnt_d   = '0;
                    blinkOn_d    = 1'b1;
                    state_d      = SHOW;
                end
                SHOW: begin
                    if (correct_q) begin
                        led_d = blinkOn_q ? playerOneHot : 4'b0000;
                    end else begin
                        led_d    = playerOneHot;
                        buzzer_d = 1'b1;
                    end
                    if (blinkCnt_q == BLINK_LAST) begin
                        blinkCnt_d = '0;
                        blinkOn_d  = ~blinkOn_q;
                    end else begin
                        blinkCnt_d = blinkCnt_q + 1'b1;
                    end
                    if (showCnt_q == SHOW_LAST) begin
                        state_d = COOLDOWN;
                    end else begin
                        showCnt_d = showCnt_q + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (!playerInputFlag) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            player_q     <= 2'd0;
            correct_q    <= 1'b0;
            showCnt_q    <= '0;
            blinkCnt_q   <= '0;
            blinkOn_q    <= 1'b0;
            led_q        <= 4'b0000;
            ready_q      <= 1'b0;
            buzzer_q     <= 1'b0;
            valid_q      <= 1'b0;
            resCorrect_q <= 1'b0;
            resPlayer_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            player_q     <= player_d;
            correct_q    <= correct_d;
            showCnt_q    <= showCnt_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkOn_q    <= blinkOn_d;
            led_q        <= led_d;
            ready_q      <= ready_d;
            buzzer_q     <= buzzer_d;
            valid_q      <= valid_d;
            resCorrect_q <= resCorrect_d;
            resPlayer_q  <= resPlayer_d;
        end
    end

    assign led_out        = led_q;
    assign ready_led      = ready_q;
    assign buzzer_out     = buzzer_q;
    assign result_valid   = valid_q;
    assign result_correct = resCorrect_q;
    assign result_player  = resPlayer_q;

endmodule

// File: tb/tb_player_feedback.sv
// Testbench for player_feedback: directed vector table, hand-written corner
// sequences and a randomized run compared against a behavioural model.
module tb_player_feedback;

    localparam int SC = 8;
    localparam int BH = 2;

    logic       clk;
    logic       rst;
    logic       gameActive;
    logic       pif;
    logic [1:0] fpf;
    logic [7:0] sw;
    logic [7:0] tg;
    logic [3:0] ledOut;
    logic       readyLed;
    logic       buzzerOut;
    logic       resultValid;
    logic       resultCorrect;
    logic [1:0] resultPlayer;

    int errors = 0;
    int checks = 0;

    player_feedback #(.SHOW_CYCLES(SC), .BLINK_HALF(BH)) dut (
        .clk             (clk),
        .rst             (rst),
        .game_active     (gameActive),
        .playerInputFlag (pif),
        .firstPlayerFlag (fpf),
        .switchInput     (sw),
        .target          (tg),
        .led_out         (ledOut),
        .ready_led       (readyLed),
        .buzzer_out      (buzzerOut),
        .result_valid    (resultValid),
        .result_correct  (resultCorrect),
        .result_player   (resultPlayer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output view: {ready, led[3:0], buzzer, valid, correct, player[1:0]}
    function automatic logic [9:0] pack(input logic r, input logic [3:0] l,
                                        input logic b, input logic v,
                                        input logic c, input logic [1:0] p);
        return {r, l, b, v, c, p};
    endfunction

    // Behavioural reference model, phrased as game phases plus elapsed time.
    localparam int P_IDLE = 0, P_LOCKED = 1, P_JUDGE = 2, P_SHOW = 3, P_COOL = 4;
    int         mPhase = P_IDLE;
    int         mAge = 0;
    logic [1:0] mPlayer = 2'd0;
    logic       mWasRight = 1'b0;
    logic       mRc = 1'b0;
    logic [1:0] mRp = 2'd0;
    logic [9:0] mExp = 10'd0;

    task automatic modelStep();
        logic [3:0] lamp;
        logic       rdy, buz, strobe;
        lamp = 4'b0000;
        rdy = 1'b0;
        buz = 1'b0;
        strobe = 1'b0;
        if (rst) begin
            mPhase = P_IDLE;
            mAge = 0;
            mPlayer = 2'd0;
            mWasRight = 1'b0;
            mRc = 1'b0;
            mRp = 2'd0;
        end else if (mPhase != P_IDLE && !gameActive) begin
            mPhase = P_IDLE;
        end else begin
            case (mPhase)
                P_IDLE: begin
                    rdy = gameActive;
                    if (gameActive && pif) begin
                        mPlayer = fpf;
                        mPhase = P_LOCKED;
                    end
                end
                P_LOCKED: begin
                    lamp[mPlayer] = 1'b1;
                    if (!pif) mPhase = P_JUDGE;
                end
                P_JUDGE: begin
                    lamp[mPlayer] = 1'b1;
                    strobe = 1'b1;
                    mWasRight = (sw == tg);
                    mRc = mWasRight;
                    mRp = mPlayer;
                    mAge = 0;
                    mPhase = P_SHOW;
                end
                P_SHOW: begin
                    if (!mWasRight || ((mAge / BH) % 2 == 0)) lamp[mPlayer] = 1'b1;
                    buz = !mWasRight;
                    mAge++;
                    if (mAge == SC) mPhase = P_COOL;
                end
                default: begin
                    if (!pif) mPhase = P_IDLE;
                end
            endcase
        end
        mExp = pack(rdy, lamp, buz, strobe, mRc, mRp);
    endtask

    // Drive one cycle of inputs, advance the model on the clock edge, settle.
    task automatic applyStimulus(input logic r, input logic ga, input logic p,
                                 input logic [1:0] f, input logic [7:0] s,
                                 input logic [7:0] t);
        @(negedge clk);
        rst = r;
        gameActive = ga;
        pif = p;
        fpf = f;
        sw = s;
        tg = t;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] expected);
        logic [9:0] actual;
        actual = pack(readyLed, ledOut, buzzerOut, resultValid, resultCorrect, resultPlayer);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %03h expected %03h (ready,led,buzz,valid,correct,player)",
                     name, actual, expected);
        end
    endtask

    task automatic stepModel(input string name, input logic r, input logic ga,
                             input logic p, input logic [1:0] f,
                             input logic [7:0] s, input logic [7:0] t);
        applyStimulus(r, ga, p, f, s, t);
        checkOutput(name, mExp);
    endtask

    typedef struct {
        logic       r, ga, p;
        logic [1:0] f;
        logic [7:0] s, t;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic r, input logic ga, input logic p,
                                   input logic [1:0] f, input logic [7:0] s,
                                   input logic [7:0] t, input logic [9:0] e);
        vec_t v;
        v.r = r; v.ga = ga; v.p = p; v.f = f; v.s = s; v.t = t; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic       rr, rga, rp;
        logic [1:0] rf;
        logic [7:0] rs, rt;

        rst = 1'b1;
        gameActive = 1'b0;
        pif = 1'b0;
        fpf = 2'd0;
        sw = 8'd0;
        tg = 8'd0;

        // Reset, idle, then a correct answer from player 2 with lockout.
        addVec(1, 1, 0, 0, 8'h00, 8'h00, pack(0, 4'b0000, 0, 0, 0, 2'd0));
        addVec(0, 1, 0, 0, 8'h00, 8'h00, pack(1, 4'b0000, 0, 0, 0, 2'd0));
        addVec(0, 1, 0, 0, 8'h00, 8'h00, pack(1, 4'b0000, 0, 0, 0, 2'd0));
        addVec(0, 1, 1, 2, 8'h00, 8'h00, pack(1, 4'b0000, 0, 0, 0, 2'd0));
        for (int k = 0; k < 4; k++)
            addVec(0, 1, 1, 2, 8'h00, 8'h00, pack(0, 4'b0100, 0, 0, 0, 2'd0));
        for (int k = 0; k < 2; k++)
            addVec(0, 1, 1, 1, 8'h00, 8'h00, pack(0, 4'b0100, 0, 0, 0, 2'd0));
        addVec(0, 1, 0, 1, 8'h3C, 8'h3C, pack(0, 4'b0100, 0, 0, 0, 2'd0));
        addVec(0, 1, 0, 1, 8'h3C, 8'h3C, pack(0, 4'b0100, 0, 1, 1, 2'd2));
        for (int k = 0; k < 8; k++)
            addVec(0, 1, 0, 1, 8'h3C, 8'h3C,
                   pack(0, ((k % 4) < 2) ? 4'b0100 : 4'b0000, 0, 0, 1, 2'd2));
        addVec(0, 1, 0, 1, 8'h3C, 8'h3C, pack(0, 4'b0000, 0, 0, 1, 2'd2));
        addVec(0, 1, 0, 1, 8'h3C, 8'h3C, pack(1, 4'b0000, 0, 0, 1, 2'd2));
        // Same player, wrong answer.
        addVec(0, 1, 1, 2, 8'h3D, 8'h3C, pack(1, 4'b0000, 0, 0, 1, 2'd2));
        addVec(0, 1, 1, 2, 8'h3D, 8'h3C, pack(0, 4'b0100, 0, 0, 1, 2'd2));
        addVec(0, 1, 0, 2, 8'h3D, 8'h3C, pack(0, 4'b0100, 0, 0, 1, 2'd2));
        addVec(0, 1, 0, 2, 8'h3D, 8'h3C, pack(0, 4'b0100, 0, 1, 0, 2'd2));
        for (int k = 0; k < 8; k++)
            addVec(0, 1, 0, 2, 8'h3D, 8'h3C, pack(0, 4'b0100, 1, 0, 0, 2'd2));
        addVec(0, 1, 0, 2, 8'h3D, 8'h3C, pack(0, 4'b0000, 0, 0, 0, 2'd2));
        addVec(0, 1, 0, 2, 8'h3D, 8'h3C, pack(1, 4'b0000, 0, 0, 0, 2'd2));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].ga, vecs[i].p, vecs[i].f, vecs[i].s, vecs[i].t);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Button held through the whole display window and into cooldown.
        stepModel("hold_capture", 0, 1, 1, 3, 8'h11, 8'h11);
        stepModel("hold_locked", 0, 1, 1, 3, 8'h11, 8'h11);
        stepModel("hold_release", 0, 1, 0, 3, 8'h11, 8'h11);
        for (int k = 0; k < 16; k++)
            stepModel($sformatf("hold_show%0d", k), 0, 1, 1, 0, 8'h11, 8'h11);
        applyStimulus(0, 1, 1, 0, 8'h11, 8'h11);
        checkOutput("hold_cooldown", pack(0, 4'b0000, 0, 0, 1, 2'd3));
        applyStimulus(0, 1, 0, 0, 8'h11, 8'h11);
        checkOutput("cool_release", pack(0, 4'b0000, 0, 0, 1, 2'd3));
        applyStimulus(0, 1, 0, 0, 8'h11, 8'h11);
        checkOutput("ready_after_cool", pack(1, 4'b0000, 0, 0, 1, 2'd3));
        applyStimulus(0, 1, 1, 0, 8'h11, 8'h11);
        checkOutput("rebuzz_capture", pack(1, 4'b0000, 0, 0, 1, 2'd3));
        applyStimulus(0, 1, 1, 0, 8'h11, 8'h11);
        checkOutput("rebuzz_locked", pack(0, 4'b0001, 0, 0, 1, 2'd3));

        // Abort in JUDGE: no strobe, feedback cleared, last result held.
        applyStimulus(0, 1, 0, 0, 8'h22, 8'h22);
        checkOutput("abort_release", pack(0, 4'b0001, 0, 0, 1, 2'd3));
        applyStimulus(0, 0, 0, 0, 8'h22, 8'h22);
        checkOutput("abort_judge", pack(0, 4'b0000, 0, 0, 1, 2'd3));
        stepModel("abort_idle", 0, 1, 0, 0, 8'h22, 8'h22);

        // Reset asserted in the middle of the display window.
        stepModel("rst_capture", 0, 1, 1, 1, 8'h00, 8'h01);
        stepModel("rst_release", 0, 1, 0, 1, 8'h00, 8'h01);
        stepModel("rst_judge", 0, 1, 0, 1, 8'h00, 8'h01);
        stepModel("rst_show0", 0, 1, 0, 1, 8'h00, 8'h01);
        stepModel("rst_show1", 0, 1, 0, 1, 8'h00, 8'h01);
        applyStimulus(1, 1, 1, 1, 8'h00, 8'h01);
        checkOutput("rst_mid_show", pack(0, 4'b0000, 0, 0, 0, 2'd0));
        stepModel("rst_after", 0, 1, 0, 1, 8'h00, 8'h01);

        // Randomized run against the model.
        rp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom_range(0, 249) == 0);
            rga = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 5) == 0) rp = ~rp;
            rf  = 2'($urandom_range(0, 3));
            rt  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 1) == 1) ? rt : 8'($urandom_range(0, 255));
            stepModel("random", rr, rga, rp, rf, rs, rt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_feedback.md
Name: player_feedback

Overview:
- Return path to the player controller pads.
- Consumes the buzz-in outputs of the controller input block (playerInputFlag, firstPlayerFlag, switchInput) and the game's current target value.
- Latches which player buzzed first and locks out the rest, judges the latched answer against the target, then drives per-player LEDs and a buzzer as feedback.
- Reports a one-cycle result strobe to the game core; its LED and buzzer outputs drive controller GPIO output pins.

Parameters:
- SHOW_CYCLES, 50000000, length of the result display in clk cycles (1 s at 50 MHz); minimum 2.
- BLINK_HALF, 6250000, half-period of the LED blink in clk cycles; minimum 1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- game_active  input  1  1 = buzz-in allowed; 0 = abort to IDLE
- playerInputFlag  input  1  1 while any player button is held
- firstPlayerFlag  input  2  index of the buzzing player, 0..3
- switchInput  input  8  registered answer from the buzzing player's switches
- target  input  8  expected answer, stable while not IDLE
- led_out  output  4  per-player LED, bit i = player i, active-high
- ready_led  output  1  1 in IDLE while game_active = 1
- buzzer_out  output  1  wrong-answer buzzer, active-high
- result_valid  output  1  one-cycle strobe when the answer is judged
- result_correct  output  1  1 = answer matched target; valid with result_valid, held until next judge
- result_player  output  2  judged player index; valid with result_valid, held until next judge

Behaviour:
- All outputs are registered. Every output value below appears the cycle after the state or condition that causes it.
- Reset (rst = 1 at a clk edge):
  - state = IDLE.
  - led_out = 0, ready_led = 0, buzzer_out = 0.
  - result_valid = 0, result_correct = 0, result_player = 0.
  - Counters and latched player cleared.
  - Reset has priority over every other input in every state, including mid-SHOW.
- IDLE:
  - ready_led = game_active; led_out = 0; buzzer_out = 0.
  - If game_active && playerInputFlag: latch player = firstPlayerFlag and go to LOCKED.
  - Otherwise stay.
- LOCKED:
  - led_out = one-hot(player), solid.
  - Changes on firstPlayerFlag are ignored; the latched player is fixed (lockout).
  - Stay while playerInputFlag = 1.
  - When playerInputFlag = 0 (button released, switchInput now frozen), go to JUDGE.
- JUDGE (exactly 1 cycle):
  - correct = (switchInput == target), full 8-bit compare.
  - Next cycle: result_valid = 1, result_correct = correct, result_player = player. State goes to SHOW with count = 0 and blink phase = ON.
- SHOW (lasts SHOW_CYCLES cycles):
  - If correct: led_out = one-hot(player) gated by blink phase. Blink starts ON and toggles after every BLINK_HALF cycles. buzzer_out = 0.
  - If wrong: led_out = one-hot(player) solid; buzzer_out = 1 for the whole window.
  - playerInputFlag is ignored.
  - After count reaches SHOW_CYCLES-1, go to COOLDOWN.
- COOLDOWN:
  - led_out = 0, buzzer_out = 0.
  - Wait for playerInputFlag = 0, then go to IDLE. This stops a held button from re-buzzing instantly.
- result_valid is high for exactly one cycle per judged answer and is 0 in all other cycles.
- game_active = 0 in LOCKED, JUDGE, SHOW or COOLDOWN:
  - Next state is IDLE; LEDs and buzzer go to 0.
  - No result_valid is issued. An abort in JUDGE suppresses the strobe.
- Simultaneous events:
  - playerInputFlag rising in the same cycle game_active rises: captured.
  - rst together with anything: rst wins.
- Counters are wide enough for SHOW_CYCLES and BLINK_HALF and do not wrap within a SHOW window.

Test Plan (bench uses SHOW_CYCLES = 8, BLINK_HALF = 2):
- Reset, game_active = 1 idle -> ready_led = 1, led_out = 0000, result_valid never asserted.
- playerInputFlag = 1 with firstPlayerFlag = 2 for 5 cycles, then firstPlayerFlag changed to 1 while still held -> led_out = 0100 throughout LOCKED (lockout holds player 2).
- Player 2 releases with switchInput = 8'h3C, target = 8'h3C:
  - One-cycle result_valid with result_correct = 1, result_player = 2.
  - led_out[2] pattern over SHOW = 1,1,0,0,1,1,0,0; buzzer_out = 0.
  - Then led_out = 0000 and return to IDLE.
- Same sequence with switchInput = 8'h3D:
  - result_correct = 0.
  - led_out = 0100 solid and buzzer_out = 1 for exactly 8 cycles.
- playerInputFlag held through SHOW and past its end -> stays in COOLDOWN with led_out = 0 and no new capture. After release, one cycle later ready_led = 1 and a new buzz is accepted.
- Aborts:
  - game_active dropped during JUDGE -> no result_valid, led_out = 0 next cycle.
  - rst asserted mid-SHOW -> all outputs at their reset values the next cycle.
